// File: rtl/i2c_pkg.sv
`default_nettype none
//----------------------------------------------------------------------------
// i2c_pkg - shared types, constants and helpers for the I2C write controller. Rev 1.0
//----------------------------------------------------------------------------
package i2c_pkg;

  typedef enum logic [2:0] {
    IDLE,
    START,
    ADDR,
    ACK_A,
    WAIT,
    DATA,
    ACK_D,
    STOP
  } i2c_state_e;

  typedef logic [1:0] quarter_t;

  localparam logic I2C_W = 1'b0;
  localparam logic I2C_R = 1'b1;

  function automatic logic [7:0] addr_byte(input logic [6:0] addr, input logic rd);
    return {addr, (rd ? I2C_R : I2C_W)};
  endfunction

endpackage
`default_nettype wire

// File: rtl/i2c_master_tx_if.sv
`default_nettype none
//----------------------------------------------------------------------------
// i2c_master_tx_if - byte handshake, status and open-drain bus pins. Rev 1.0
//----------------------------------------------------------------------------
interface i2c_master_tx_if;

  logic       start;
  logic [6:0] addr;
  logic [7:0] din;
  logic       din_last;
  logic       din_valid;
  logic       din_ready;
  logic       busy;
  logic       done;
  logic       nack;
  logic       scl_in;
  logic       sda_in;
  logic       scl_oe;
  logic       sda_oe;

  modport master (
    input  start, addr, din, din_last, din_valid, scl_in, sda_in,
    output din_ready, busy, done, nack, scl_oe, sda_oe
  );

  modport slave (
    output start, addr, din, din_last, din_valid, scl_in, sda_in,
    input  din_ready, busy, done, nack, scl_oe, sda_oe
  );

endinterface
`default_nettype wire

// File: rtl/i2c_qtick.sv
`default_nettype none
//----------------------------------------------------------------------------
// i2c_qtick - quarter-SCL-period tick generator, frozen at zero by hold. Rev 1.0
//----------------------------------------------------------------------------
module i2c_qtick #(
  parameter int QDIV = 125
) (
  input  logic clk,
  input  logic key,
  input  logic hold,
  output logic qt
);

  localparam int CW = (QDIV > 1) ? $clog2(QDIV) : 1;
  localparam logic [CW-1:0] LAST = CW'(QDIV - 1);

  logic [CW-1:0] cnt;

  always_ff @(posedge clk or negedge key) begin
    if (!key) begin
      cnt <= '0;
    end else if (hold || (cnt == LAST)) begin
      cnt <= '0;
    end else begin
      cnt <= cnt + 1'b1;
    end
  end

  assign qt = !hold && (cnt == LAST);

endmodule
`default_nettype wire

// File: rtl/i2c_master_tx.sv
`default_nettype none
//----------------------------------------------------------------------------
// i2c_master_tx - single-master I2C write controller: START, addr+W, bytes, STOP. Rev 1.0
//----------------------------------------------------------------------------
module i2c_master_tx
  import i2c_pkg::*;
#(
  parameter int QDIV = 125
) (
  input  logic            clk,
  input  logic            key,
  i2c_master_tx_if.master bus
);

  i2c_state_e state, state_n;
  quarter_t   q, q_n;
  logic [2:0] bitcnt, bitcnt_n;
  logic [7:0] sh, sh_n;
  logic       last, last_n;
  logic       ackb, ackb_n;
  logic       nack, nack_n;
  logic       hold, qt;
  logic       scl_oe, sda_oe, din_ready, done;

  // Ticks freeze while idle, while parked for data, and while a slave stretches SCL in q1.
  assign hold = (state == IDLE) || (state == WAIT) || ((q == 2'd1) && !bus.scl_in);

  i2c_qtick #(.QDIV(QDIV)) u_qtick (
    .clk  (clk),
    .key  (key),
    .hold (hold),
    .qt   (qt)
  );

  always_ff @(posedge clk or negedge key) begin
    if (!key) begin
      state  <= IDLE;
      q      <= '0;
      bitcnt <= '0;
      sh     <= '0;
      last   <= 1'b0;
      ackb   <= 1'b0;
      nack   <= 1'b0;
    end else begin
      state  <= state_n;
      q      <= q_n;
      bitcnt <= bitcnt_n;
      sh     <= sh_n;
      last   <= last_n;
      ackb   <= ackb_n;
      nack   <= nack_n;
    end
  end

  always_comb begin
    state_n   = state;
    q_n       = q;
    bitcnt_n  = bitcnt;
    sh_n      = sh;
    last_n    = last;
    ackb_n    = ackb;
    nack_n    = nack;
    scl_oe    = 1'b0;
    sda_oe    = 1'b0;
    din_ready = 1'b0;
    done      = 1'b0;

    case (state)
      IDLE: begin
        if (bus.start) begin
          state_n = START;
          sh_n    = addr_byte(bus.addr, 1'b0);
          nack_n  = 1'b0;
        end
      end
      START: begin
        scl_oe = (q == 2'd3);
        sda_oe = (q != 2'd0);
      end
      ADDR, DATA: begin
        scl_oe = (q == 2'd0) || (q == 2'd3);
        sda_oe = !sh[7];
      end
      ACK_A, ACK_D: begin
        scl_oe = (q == 2'd0) || (q == 2'd3);
      end
      WAIT: begin
        scl_oe    = 1'b1;
        din_ready = 1'b1;
        if (bus.din_valid) begin
          sh_n    = bus.din;
          last_n  = bus.din_last;
          state_n = DATA;
        end
      end
      STOP: begin
        scl_oe = (q == 2'd0);
        sda_oe = (q <= 2'd1);
      end
      default: ;
    endcase

    // qt never fires in IDLE or WAIT, so this only advances the bit-level states.
    if (qt) begin
      q_n = q + 2'd1;
      if (q == 2'd1) begin
        ackb_n = bus.sda_in;
      end
      if (q == 2'd3) begin
        case (state)
          START: state_n = ADDR;
          ADDR, DATA: begin
            sh_n     = {sh[6:0], 1'b0};
            bitcnt_n = bitcnt + 3'd1;
            if (bitcnt == 3'd7) begin
              state_n = (state == ADDR) ? ACK_A : ACK_D;
            end
          end
          ACK_A, ACK_D: begin
            if (ackb) begin
              nack_n  = 1'b1;
              state_n = STOP;
            end else if ((state == ACK_D) && last) begin
              state_n = STOP;
            end else begin
              state_n = WAIT;
            end
          end
          STOP: begin
            done    = 1'b1;
            state_n = IDLE;
          end
          default: ;
        endcase
      end
    end
  end

  assign bus.scl_oe    = scl_oe;
  assign bus.sda_oe    = sda_oe;
  assign bus.din_ready = din_ready;
  assign bus.done      = done;
  assign bus.busy      = (state != IDLE);
  assign bus.nack      = nack;

endmodule
`default_nettype wire

// File: tb/tb_i2c_master_tx.sv
`default_nettype none
//----------------------------------------------------------------------------
// tb_i2c_master_tx - directed bench with open-drain bus and slave model. Rev 1.0
//----------------------------------------------------------------------------
module tb_i2c_master_tx;

  localparam int QDIV = 4;

  logic clk = 1'b0;
  logic key = 1'b0;

  i2c_master_tx_if bus();

  i2c_master_tx #(.QDIV(QDIV)) dut (
    .clk (clk),
    .key (key),
    .bus (bus)
  );

  always #5 clk = ~clk;

  logic s_scl = 1'b0;
  logic s_sda = 1'b0;
  assign bus.scl_in = !(bus.scl_oe || s_scl);
  assign bus.sda_in = !(bus.sda_oe || s_sda);

  int         checks = 0;
  int         errors = 0;
  int         cyc = 0;
  logic       p_scl = 1'b1;
  logic       p_sda = 1'b1;
  int         rx_bits = 0;
  int         nbytes = 0;
  int         starts = 0;
  int         stops = 0;
  int         dones = 0;
  bit         in_ack = 1'b0;
  bit         nack_addr = 1'b0;
  int         st_byte = -1;
  int         st_bit = 0;
  int         st_cnt = 0;
  logic [7:0] rx_sh = '0;
  logic [7:0] rx_q[$];
  int         rise_t[$];

  // Slave: decodes START/STOP, shifts bits on SCL rise, ACKs (or NACKs the address), stretches once.
  always @(posedge clk) begin
    cyc++;
    if (bus.done) dones++;
    p_scl <= bus.scl_in;
    p_sda <= bus.sda_in;
    if (st_cnt > 0) begin
      st_cnt--;
      if (st_cnt == 0) s_scl <= 1'b0;
    end
    if (!key) begin
      rx_bits = 0;
      in_ack  = 1'b0;
      st_cnt  = 0;
      s_sda  <= 1'b0;
      s_scl  <= 1'b0;
    end else if (p_scl && bus.scl_in && p_sda && !bus.sda_in) begin
      starts++;
      rx_bits = 0;
      nbytes  = 0;
      in_ack  = 1'b0;
    end else if (p_scl && bus.scl_in && !p_sda && bus.sda_in) begin
      stops++;
      rx_bits = 0;
      in_ack  = 1'b0;
    end else if (!p_scl && bus.scl_in) begin
      rise_t.push_back(cyc);
      if (!in_ack) begin
        rx_sh = {rx_sh[6:0], bus.sda_in};
        rx_bits++;
      end
    end else if (p_scl && !bus.scl_in) begin
      if (in_ack) begin
        s_sda <= 1'b0;
        in_ack = 1'b0;
      end else if (rx_bits == 8) begin
        rx_q.push_back(rx_sh);
        rx_bits = 0;
        in_ack  = 1'b1;
        s_sda  <= !((nbytes == 0) && nack_addr);
        nbytes++;
      end else if ((nbytes == st_byte) && (rx_bits == st_bit)) begin
        s_scl  <= 1'b1;
        st_cnt  = 30;
        st_byte = -1;
      end
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic clear_mon();
    rx_q.delete();
    rise_t.delete();
    starts    = 0;
    stops     = 0;
    dones     = 0;
    st_byte   = -1;
    nack_addr = 1'b0;
  endtask

  task automatic do_start(input logic [6:0] a);
    bus.addr  = a;
    bus.start = 1'b1;
    tick();
    bus.start = 1'b0;
  endtask

  task automatic test_reset();
    key       = 1'b0;
    bus.start = 1'b1;
    bus.addr  = 7'h3C;
    repeat (3) tick();
    checks++;
    if ({bus.scl_oe, bus.sda_oe, bus.busy, bus.done, bus.nack, bus.din_ready} !== 6'b0) begin
      errors++;
      $display("FAIL reset_outputs: got %b expected 000000",
               {bus.scl_oe, bus.sda_oe, bus.busy, bus.done, bus.nack, bus.din_ready});
    end
    bus.start = 1'b0;
    key = 1'b1;
    repeat (3) tick();
    checks++;
    if (bus.busy !== 1'b0) begin
      errors++;
      $display("FAIL reset_start_ignored: busy got %b expected 0", bus.busy);
    end
  endtask

  task automatic test_single();
    int k;
    clear_mon();
    bus.din = 8'hA5; bus.din_last = 1'b1; bus.din_valid = 1'b1;
    do_start(7'h3C);
    checks++;
    if (bus.busy !== 1'b1) begin
      errors++;
      $display("FAIL single_busy: got %b expected 1", bus.busy);
    end
    k = 0;
    while (!bus.din_ready && k < 400) begin tick(); k++; end
    checks++;
    if (k !== 160) begin
      errors++;
      $display("FAIL single_ready_latency: got %0d expected 160", k);
    end
    tick();
    bus.din_valid = 1'b0;
    checks++;
    if (bus.din_ready !== 1'b0) begin
      errors++;
      $display("FAIL single_ready_drop: got %b expected 0", bus.din_ready);
    end
    k = 0;
    while (!bus.done && k < 400) begin tick(); k++; end
    checks++;
    if (k !== 159) begin
      errors++;
      $display("FAIL single_done_latency: got %0d expected 159", k);
    end
    tick();
    checks++;
    if ({bus.busy, bus.done} !== 2'b00) begin
      errors++;
      $display("FAIL single_end_flags: busy,done got %b expected 00", {bus.busy, bus.done});
    end
    repeat (10) tick();
    checks++;
    if (((rx_q.size() == 2) ? {rx_q[0], rx_q[1]} : 16'hxxxx) !== 16'h78A5) begin
      errors++;
      $display("FAIL single_bytes: got %0d bytes expected 78 A5", rx_q.size());
    end
    checks++;
    if ({starts, stops, dones} !== {32'd1, 32'd1, 32'd1}) begin
      errors++;
      $display("FAIL single_framing: starts %0d stops %0d dones %0d expected 1 1 1", starts, stops, dones);
    end
    checks++;
    if (bus.nack !== 1'b0) begin
      errors++;
      $display("FAIL single_nack: got %b expected 0", bus.nack);
    end
    checks++;
    if (((rise_t.size() == 19) ? (rise_t[1] - rise_t[0]) : -1) !== 16) begin
      errors++;
      $display("FAIL single_bit_period: rises %0d, period got %0d expected 16", rise_t.size(),
               (rise_t.size() > 1) ? (rise_t[1] - rise_t[0]) : -1);
    end
    checks++;
    if (((rise_t.size() > 8) ? (rise_t[8] - rise_t[0]) : -1) !== 128) begin
      errors++;
      $display("FAIL single_addr_span: got %0d expected 128",
               (rise_t.size() > 8) ? (rise_t[8] - rise_t[0]) : -1);
    end
  endtask

  task automatic test_addr_nack();
    int k;
    int ready_seen;
    clear_mon();
    nack_addr = 1'b1;
    bus.din = 8'h55; bus.din_last = 1'b1; bus.din_valid = 1'b1;
    do_start(7'h50);
    k = 0;
    ready_seen = 0;
    while (!bus.done && k < 400) begin
      tick(); k++;
      if (bus.din_ready) ready_seen++;
    end
    checks++;
    if (k !== 175) begin
      errors++;
      $display("FAIL nack_done_latency: got %0d expected 175", k);
    end
    checks++;
    if (ready_seen !== 0) begin
      errors++;
      $display("FAIL nack_ready: din_ready cycles got %0d expected 0", ready_seen);
    end
    bus.din_valid = 1'b0;
    repeat (10) tick();
    checks++;
    if (bus.nack !== 1'b1) begin
      errors++;
      $display("FAIL nack_flag: got %b expected 1", bus.nack);
    end
    checks++;
    if (((rx_q.size() == 1) ? rx_q[0] : 8'hxx) !== 8'hA0) begin
      errors++;
      $display("FAIL nack_addr_byte: got %0d bytes expected A0", rx_q.size());
    end
    checks++;
    if ({stops, dones} !== {32'd1, 32'd1}) begin
      errors++;
      $display("FAIL nack_framing: stops %0d dones %0d expected 1 1", stops, dones);
    end
  endtask

  task automatic test_gap();
    int k;
    int scl_hi;
    int unready;
    clear_mon();
    bus.din_valid = 1'b0;
    do_start(7'h2A);
    checks++;
    if (bus.nack !== 1'b0) begin
      errors++;
      $display("FAIL gap_nack_clear: got %b expected 0", bus.nack);
    end
    k = 0;
    while (!bus.din_ready && k < 400) begin tick(); k++; end
    bus.din = 8'h12; bus.din_last = 1'b0; bus.din_valid = 1'b1;
    tick();
    bus.din_valid = 1'b0;
    k = 0;
    while (!bus.din_ready && k < 400) begin tick(); k++; end
    checks++;
    if (k !== 144) begin
      errors++;
      $display("FAIL gap_byte_latency: got %0d expected 144", k);
    end
    scl_hi = 0;
    unready = 0;
    for (int i = 0; i < 50; i++) begin
      tick();
      if (bus.scl_in) scl_hi++;
      if (!bus.din_ready) unready++;
    end
    checks++;
    if ({scl_hi, unready} !== {32'd0, 32'd0}) begin
      errors++;
      $display("FAIL gap_scl_low: scl high cycles %0d, not-ready cycles %0d expected 0 0", scl_hi, unready);
    end
    bus.din = 8'h34; bus.din_last = 1'b1; bus.din_valid = 1'b1;
    tick();
    bus.din_valid = 1'b0;
    k = 0;
    while (!bus.done && k < 400) begin tick(); k++; end
    repeat (10) tick();
    checks++;
    if (((rx_q.size() == 3) ? {rx_q[0], rx_q[1], rx_q[2]} : 24'hxxxxxx) !== 24'h541234) begin
      errors++;
      $display("FAIL gap_bytes: got %0d bytes expected 54 12 34", rx_q.size());
    end
    checks++;
    if ({starts, stops, dones, 31'd0, bus.nack} !== {32'd1, 32'd1, 32'd1, 32'd0}) begin
      errors++;
      $display("FAIL gap_framing: starts %0d stops %0d dones %0d nack %b expected 1 1 1 0",
               starts, stops, dones, bus.nack);
    end
  endtask

  task automatic test_stretch();
    int k;
    clear_mon();
    st_byte = 1;
    st_bit  = 3;
    bus.din = 8'hFF; bus.din_last = 1'b1; bus.din_valid = 1'b1;
    do_start(7'h3C);
    k = 0;
    while (!bus.din_ready && k < 400) begin tick(); k++; end
    tick();
    bus.din_valid = 1'b0;
    k = 0;
    while (!bus.done && k < 600) begin tick(); k++; end
    repeat (10) tick();
    checks++;
    if (((rx_q.size() == 2) ? rx_q[1] : 8'hxx) !== 8'hFF) begin
      errors++;
      $display("FAIL stretch_byte: got %0d bytes expected data FF", rx_q.size());
    end
    checks++;
    if (((rise_t.size() == 19) ? (rise_t[12] - rise_t[11]) : -1) !== 39) begin
      errors++;
      $display("FAIL stretch_held_bit: rises %0d, period got %0d expected 39", rise_t.size(),
               (rise_t.size() > 12) ? (rise_t[12] - rise_t[11]) : -1);
    end
    checks++;
    if (((rise_t.size() > 14) ? {rise_t[13] - rise_t[12], rise_t[14] - rise_t[13]} : 64'd0)
        !== {32'd16, 32'd16}) begin
      errors++;
      $display("FAIL stretch_after_period: got %0d,%0d expected 16,16",
               (rise_t.size() > 14) ? (rise_t[13] - rise_t[12]) : -1,
               (rise_t.size() > 14) ? (rise_t[14] - rise_t[13]) : -1);
    end
  endtask

  task automatic test_reset_mid();
    int k;
    clear_mon();
    bus.din = 8'h00; bus.din_last = 1'b1; bus.din_valid = 1'b1;
    do_start(7'h3C);
    k = 0;
    while (!bus.din_ready && k < 400) begin tick(); k++; end
    tick();
    bus.din_valid = 1'b0;
    k = 0;
    while (rise_t.size() < 15 && k < 400) begin tick(); k++; end
    repeat (10) tick();
    checks++;
    if ({bus.scl_oe, bus.sda_oe, bus.busy} !== 3'b111) begin
      errors++;
      $display("FAIL rstmid_before: scl_oe,sda_oe,busy got %b expected 111",
               {bus.scl_oe, bus.sda_oe, bus.busy});
    end
    #1 key = 1'b0;
    #1;
    checks++;
    if ({bus.scl_oe, bus.sda_oe, bus.busy, bus.din_ready, bus.done} !== 5'b0) begin
      errors++;
      $display("FAIL rstmid_async: got %b expected 00000",
               {bus.scl_oe, bus.sda_oe, bus.busy, bus.din_ready, bus.done});
    end
    repeat (3) tick();
    key = 1'b1;
    repeat (3) tick();
    clear_mon();
    bus.din = 8'h5A; bus.din_last = 1'b1; bus.din_valid = 1'b1;
    do_start(7'h3C);
    k = 0;
    while (!bus.din_ready && k < 400) begin tick(); k++; end
    tick();
    bus.din_valid = 1'b0;
    k = 0;
    while (!bus.done && k < 400) begin tick(); k++; end
    repeat (10) tick();
    checks++;
    if (((rx_q.size() == 2) ? {rx_q[0], rx_q[1]} : 16'hxxxx) !== 16'h785A) begin
      errors++;
      $display("FAIL rstmid_recover_bytes: got %0d bytes expected 78 5A", rx_q.size());
    end
    checks++;
    if ({starts, stops, dones, 31'd0, bus.nack} !== {32'd1, 32'd1, 32'd1, 32'd0}) begin
      errors++;
      $display("FAIL rstmid_recover_framing: starts %0d stops %0d dones %0d nack %b expected 1 1 1 0",
               starts, stops, dones, bus.nack);
    end
  endtask

  task automatic test_busy_start();
    int k;
    clear_mon();
    bus.din = 8'hC3; bus.din_last = 1'b1; bus.din_valid = 1'b1;
    do_start(7'h3C);
    repeat (20) tick();
    do_start(7'h11);
    k = 0;
    while (!bus.din_ready && k < 400) begin tick(); k++; end
    bus.start = 1'b1;
    tick();
    bus.start = 1'b0;
    bus.din_valid = 1'b0;
    k = 0;
    while (!bus.done && k < 400) begin tick(); k++; end
    repeat (200) tick();
    checks++;
    if ({starts, dones} !== {32'd1, 32'd1}) begin
      errors++;
      $display("FAIL busy_start_single: starts %0d dones %0d expected 1 1", starts, dones);
    end
    checks++;
    if (((rx_q.size() == 2) ? {rx_q[0], rx_q[1]} : 16'hxxxx) !== 16'h78C3) begin
      errors++;
      $display("FAIL busy_start_bytes: got %0d bytes expected 78 C3", rx_q.size());
    end
    checks++;
    if (bus.busy !== 1'b0) begin
      errors++;
      $display("FAIL busy_start_idle: busy got %b expected 0", bus.busy);
    end
  endtask

  initial begin
    bus.start     = 1'b0;
    bus.addr      = '0;
    bus.din       = '0;
    bus.din_last  = 1'b0;
    bus.din_valid = 1'b0;
    test_reset();
    test_single();
    test_addr_nack();
    test_gap();
    test_stretch();
    test_reset_mid();
    test_busy_start();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
`default_nettype wire

// File: doc/i2c_master_tx.md
# i2c_master_tx

I2C single-master write controller: generates START, a 7-bit address with W bit, a stream of data bytes, and STOP on an open-drain SCL/SDA pair. It is the driving end of the bus that the I2C analyzer sniffs. It is used on the DE1-SoC to stimulate slave devices and to produce known traffic for analyzer bring-up. Data bytes arrive through a valid/ready handshake; slave NACKs are reported.

## Interface
- `QDIV`, default 125: `clk` cycles per quarter SCL period (50 MHz / (4·125) = 100 kHz); legal range ≥ 2.
- `clk`  in  1  system clock.
- `key`  in  1  reset, asynchronous, active-low.
- `start`  in  1  request a transaction; sampled only in IDLE.
- `addr`  in  7  slave address; latched when `start` is accepted.
- `din`  in  8  data byte, sent MSB first.
- `din_last`  in  1  marks `din` as the final byte.
- `din_valid`  in  1  `din`/`din_last` valid.
- `din_ready`  out  1  controller can take a byte; transfer occurs when `din_valid & din_ready`.
- `busy`  out  1  transaction in progress.
- `done`  out  1  one-cycle pulse when STOP completes.
- `nack`  out  1  sticky flag: slave NACKed; cleared when the next `start` is accepted.
- `scl_in`, `sda_in`  in  1 each  bus levels, already synchronized.
- `scl_oe`, `sda_oe`  out  1 each  1 = pull line low, 0 = release.

## Operation
- Quarter tick `qt`: a counter 0..QDIV-1 pulses on wrap. All bus actions occur on `qt`, except `din` acceptance, which is immediate.
- Each bit takes 4 quarters:
  - q0: SCL low, drive SDA.
  - q1: release SCL.
  - q2: SCL high; sample `sda_in` at q2 entry.
  - q3: pull SCL low.
- Clock stretching: q1 advances to q2 only when `scl_in` = 1. The tick counter holds at 0 while waiting.
- State sequence:
  - IDLE → START: on `start`. Latch `addr`, set `busy`, clear `nack`.
  - START: q0 release both lines; q1 SDA low; q2 hold; q3 SCL low.
  - START → ADDR: shift {addr, 1'b0} as 8 bits.
  - ADDR → ACK_A: release SDA for 1 bit and sample. 0 = ACK → WAIT. 1 = NACK → set `nack`, → STOP.
  - WAIT: `din_ready` = 1 and SCL held low indefinitely. Handshake latches the byte and `din_last` → DATA.
  - DATA → ACK_D (8 bits, then 1 ack bit). NACK → `nack`, STOP. ACK with last = 1 → STOP. ACK with last = 0 → WAIT.
  - STOP: q0 SDA low; q1 release SCL (stretch-aware); q2 release SDA; q3 pulse `done`, clear `busy` → IDLE.
- `start` asserted while `busy` is ignored, not queued.
- `din_ready` is 0 in every state except WAIT. A byte offered outside WAIT is not consumed.
- Bit counter is 3 bits and wraps 7 → 0 at byte end.
- No arbitration; single master assumed on bus.

## Timing
- `key` low: `scl_oe`=`sda_oe`=0, `busy`=0, `done`=0, `nack`=0, `din_ready`=0, state IDLE. Takes effect asynchronously.
- Reset mid-transaction releases both lines immediately; no STOP is generated.
- `start` accepted on edge N: `busy` = 1 from N+1; first `qt` no later than N+QDIV.
- Unstretched bit period is exactly 4·QDIV clk. Address phase plus ack is 36·QDIV.
- `din_ready` rises in the cycle after the ack-bit q3 and falls in the cycle after handshake.
- Simultaneous `start` and reset: reset wins.
- `done` and `busy` fall in the same cycle.

## Structure
- Package `i2c_pkg`:
  - `i2c_state_e` with IDLE, START, ADDR, ACK_A, WAIT, DATA, ACK_D, STOP.
  - 2-bit `quarter_t`.
  - Constants `I2C_W = 1'b0` and `I2C_R = 1'b1`.
- Sub-module `i2c_qtick`: parameter `QDIV`; inputs `clk`, `key`, `hold`; output `qt`.
- Remainder is one FSM with a shift register and bit counter.

## Test plan
All scenarios use `QDIV=4` with an open-drain bus model and a slave model.
- Addr 0x3C, single byte 0xA5 with last, slave ACKs → bus shows START, 0x78, ACK, 0xA5, ACK, STOP; one `done`; `nack`=0; bit period 16 clk.
- Addr 0x50, slave NACKs address → `nack`=1, STOP follows, `din_ready` never asserted, `done` pulses.
- Two bytes 0x12, 0x34, with second `din_valid` delayed 50 clk → SCL low throughout the gap, then both bytes ACKed, STOP.
- Slave holds `scl_in` low 30 clk at bit 3 of 0xFF → no SCL-high phase during hold; following bits keep 16-clk period.
- `key` low during data bit 5 → `scl_oe`/`sda_oe` = 0 before the next clk edge, `busy`=0; a subsequent `start` runs a clean transaction.
- `start` pulsed while `busy` → ignored; exactly one `done` results.
